// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - parametrised multi-digit modulo up/down counter with load, clear and terminal count
module bcd_counter_n #(
    parameter int DIGITS    = 2,
    parameter int DIGIT_MOD = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap
);

    localparam logic [3:0] MAX_DIGIT = 4'(DIGIT_MOD - 1);
    localparam logic [4:0] MOD_5B    = 5'(DIGIT_MOD);

    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_clean;
    logic                at_term;

    // Ripple carry (up) or borrow (down) from digit 0 upward; a carry out of
    // the top digit means every digit sits at the terminal value.
    always_comb begin : step_logic
        logic       carry;
        logic [3:0] d;
        carry    = 1'b1;
        d        = 4'd0;
        step_val = count;
        for (int k = 0; k < DIGITS; k++) begin
            d = count[4*k +: 4];
            if (up_dn) begin
                if (carry) begin
                    step_val[4*k +: 4] = (d == MAX_DIGIT) ? 4'd0 : d + 4'd1;
                end
                carry = carry & (d == MAX_DIGIT);
            end else begin
                if (carry) begin
                    step_val[4*k +: 4] = (d == 4'd0) ? MAX_DIGIT : d - 4'd1;
                end
                carry = carry & (d == 4'd0);
            end
        end
        at_term = carry;
    end

    // Out-of-range load digits are forced to zero so no digit ever leaves 0..DIGIT_MOD-1
    always_comb begin
        load_clean = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if ({1'b0, load_val[4*k +: 4]} < MOD_5B) begin
                load_clean[4*k +: 4] = load_val[4*k +: 4];
            end
        end
    end

    // Terminal count only when this edge would actually take a count step
    always_comb begin
        tc = en & ~clear & ~load & at_term;
    end

    // State update with priority clear > load > en; wrap marks a step taken from terminal
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clean;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= step_val;
            wrap  <= at_term;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule
